// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing one core-chain request bus between bridge sources A and B.
// Optional read timeout enabled by defining BRIDGE_ARB_TIMEOUT_EN.
module bridge_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_data,
  input  logic                  a_req_rw,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  output logic [DATA_WIDTH-1:0] a_res_data,
  output logic                  a_res_valid,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_data,
  input  logic                  b_req_rw,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  output logic [DATA_WIDTH-1:0] b_res_data,
  output logic                  b_res_valid,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_rw,
  output logic                  bus_valid,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_rvalid
);

  // state   | meaning
  // IDLE    | arbitrate, ready offered to the granted source
  // ISSUE   | bus_valid strobe with the latched request
  // WAIT    | read outstanding, waiting for bus_rvalid
  // RESPOND | res_valid strobe to the owning source
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state_q, state_d;
  logic   last_q, last_d, owner_q, owner_d;  // 1 = source B
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_data_q, bus_data_d;
  logic [DATA_WIDTH-1:0] a_res_data_q, a_res_data_d, b_res_data_q, b_res_data_d;
  logic bus_rw_q, bus_rw_d, bus_valid_q, bus_valid_d;
  logic a_res_valid_q, a_res_valid_d, b_res_valid_q, b_res_valid_d;
  logic grant_b, accept, rsp_fire;
  logic [DATA_WIDTH-1:0] rsp_data;

`ifdef BRIDGE_ARB_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer_q, timer_d;
`endif

  // On a tie the source that did not win last time gets the bus.
  assign grant_b     = b_req_valid && (!a_req_valid || !last_q);
  assign a_req_ready = (state_q == IDLE) && a_req_valid && !grant_b;
  assign b_req_ready = (state_q == IDLE) && grant_b;
  assign accept      = a_req_ready || b_req_ready;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    bus_addr_d    = bus_addr_q;
    bus_data_d    = bus_data_q;
    bus_rw_d      = bus_rw_q;
    bus_valid_d   = 1'b0;
    a_res_data_d  = a_res_data_q;
    b_res_data_d  = b_res_data_q;
    a_res_valid_d = 1'b0;
    b_res_valid_d = 1'b0;
    rsp_fire      = 1'b0;
    rsp_data      = bus_rdata;
`ifdef BRIDGE_ARB_TIMEOUT_EN
    timer_d       = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d     = grant_b;
          last_d      = grant_b;
          bus_addr_d  = grant_b ? b_req_addr : a_req_addr;
          bus_data_d  = grant_b ? b_req_data : a_req_data;
          bus_rw_d    = grant_b ? b_req_rw   : a_req_rw;
          bus_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = bus_rw_q ? IDLE : WAIT;
`ifdef BRIDGE_ARB_TIMEOUT_EN
        timer_d = TIMER_W'(TIMEOUT_CYCLES);
`endif
      end
      WAIT: begin
        if (bus_rvalid) begin
          rsp_fire = 1'b1;
          rsp_data = bus_rdata;
        end
`ifdef BRIDGE_ARB_TIMEOUT_EN
        else if (timer_q == '0) begin
          rsp_fire = 1'b1;
          rsp_data = '1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
`endif
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rsp_fire) begin
      state_d = RESPOND;
      if (owner_q) begin
        b_res_valid_d = 1'b1;
        b_res_data_d  = rsp_data;
      end else begin
        a_res_valid_d = 1'b1;
        a_res_data_d  = rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      owner_q       <= 1'b0;
      bus_addr_q    <= '0;
      bus_data_q    <= '0;
      bus_rw_q      <= 1'b0;
      bus_valid_q   <= 1'b0;
      a_res_data_q  <= '0;
      b_res_data_q  <= '0;
      a_res_valid_q <= 1'b0;
      b_res_valid_q <= 1'b0;
`ifdef BRIDGE_ARB_TIMEOUT_EN
      timer_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      bus_addr_q    <= bus_addr_d;
      bus_data_q    <= bus_data_d;
      bus_rw_q      <= bus_rw_d;
      bus_valid_q   <= bus_valid_d;
      a_res_data_q  <= a_res_data_d;
      b_res_data_q  <= b_res_data_d;
      a_res_valid_q <= a_res_valid_d;
      b_res_valid_q <= b_res_valid_d;
`ifdef BRIDGE_ARB_TIMEOUT_EN
      timer_q       <= timer_d;
`endif
    end
  end

  assign bus_addr    = bus_addr_q;
  assign bus_data    = bus_data_q;
  assign bus_rw      = bus_rw_q;
  assign bus_valid   = bus_valid_q;
  assign a_res_data  = a_res_data_q;
  assign b_res_data  = b_res_data_q;
  assign a_res_valid = a_res_valid_q;
  assign b_res_valid = b_res_valid_q;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Bench for bridge_arbiter: directed scenarios plus random traffic against a cycle-timed
// transaction model (grant rule, issue/response latencies, held bus and response data).
module tb_bridge_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a_req_addr, b_req_addr, bus_addr;
  logic [DW-1:0] a_req_data, b_req_data, bus_data, a_res_data, b_res_data, bus_rdata;
  logic          a_req_rw, a_req_valid, a_req_ready, a_res_valid;
  logic          b_req_rw, b_req_valid, b_req_ready, b_res_valid;
  logic          bus_rw, bus_valid, bus_rvalid;

  bridge_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .a_req_addr(a_req_addr), .a_req_data(a_req_data), .a_req_rw(a_req_rw),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_res_data(a_res_data), .a_res_valid(a_res_valid),
    .b_req_addr(b_req_addr), .b_req_data(b_req_data), .b_req_rw(b_req_rw),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_res_data(b_res_data), .b_res_valid(b_res_valid),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_rw(bus_rw), .bus_valid(bus_valid),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rw;
  } req_t;

  req_t qa[$], qb[$];

  int errors = 0;
  int checks = 0;
  int cyc;

  // transaction model
  int          free_at, wait_from, bus_at, res_at;
  bit          m_last_b, m_owner_b, res_b;
  logic [15:0] m_addr, m_data, m_res_a, m_res_b;
  logic        m_rw;

  // stimulus control
  int          rsp_at, rsp_delay, stray_pct;
  bit          rsp_rand;
  logic [15:0] rsp_value;
  bit          acc_a, acc_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    free_at   = 0;
    wait_from = -1;
    bus_at    = -1;
    res_at    = -1;
    m_last_b  = 1'b1;
    m_owner_b = 1'b0;
    res_b     = 1'b0;
    m_addr    = '0;
    m_data    = '0;
    m_rw      = 1'b0;
    m_res_a   = '0;
    m_res_b   = '0;
  endtask

  task automatic respond(input logic [15:0] d);
    res_at = cyc + 1;
    res_b  = m_owner_b;
    if (m_owner_b) m_res_b = d;
    else           m_res_a = d;
    free_at   = cyc + 2;
    wait_from = -1;
  endtask

  // Inputs for the current cycle are already driven; checks readies, advances the model
  // across the coming edge, then checks the registered outputs of the next cycle.
  task automatic step();
    bit fr, ea, eb;
    #1;
    fr = (cyc >= free_at);
    ea = fr && a_req_valid && (!b_req_valid || m_last_b);
    eb = fr && b_req_valid && (!a_req_valid || !m_last_b);
    chk("a_req_ready", {31'd0, a_req_ready}, {31'd0, ea});
    chk("b_req_ready", {31'd0, b_req_ready}, {31'd0, eb});
    acc_a = ea;
    acc_b = eb;
    if (ea || eb) begin
      m_owner_b = eb;
      m_last_b  = eb;
      m_addr    = eb ? b_req_addr : a_req_addr;
      m_data    = eb ? b_req_data : a_req_data;
      m_rw      = eb ? b_req_rw   : a_req_rw;
      bus_at    = cyc + 1;
      if (m_rw) free_at = cyc + 2;
      else begin
        wait_from = cyc + 2;
        free_at   = 1 << 30;
      end
    end else if (wait_from >= 0 && cyc >= wait_from) begin
      if (bus_rvalid) respond(bus_rdata);
`ifdef BRIDGE_ARB_TIMEOUT_EN
      else if (cyc == wait_from + TO) respond(16'hFFFF);
`endif
    end
    @(negedge clk);
    cyc++;
    chk("bus_valid",   {31'd0, bus_valid},   {31'd0, bus_at == cyc});
    chk("bus_addr",    {16'd0, bus_addr},    {16'd0, m_addr});
    chk("bus_data",    {16'd0, bus_data},    {16'd0, m_data});
    chk("bus_rw",      {31'd0, bus_rw},      {31'd0, m_rw});
    chk("a_res_valid", {31'd0, a_res_valid}, {31'd0, (res_at == cyc) && !res_b});
    chk("b_res_valid", {31'd0, b_res_valid}, {31'd0, (res_at == cyc) && res_b});
    chk("a_res_data",  {16'd0, a_res_data},  {16'd0, m_res_a});
    chk("b_res_data",  {16'd0, b_res_data},  {16'd0, m_res_b});
  endtask

  task automatic do_reset();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    bus_rvalid  = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst a_req_ready", {31'd0, a_req_ready}, 32'd0);
    chk("rst b_req_ready", {31'd0, b_req_ready}, 32'd0);
    chk("rst bus_valid",   {31'd0, bus_valid},   32'd0);
    chk("rst bus_addr",    {16'd0, bus_addr},    32'd0);
    chk("rst bus_data",    {16'd0, bus_data},    32'd0);
    chk("rst bus_rw",      {31'd0, bus_rw},      32'd0);
    chk("rst a_res_valid", {31'd0, a_res_valid}, 32'd0);
    chk("rst b_res_valid", {31'd0, b_res_valid}, 32'd0);
    chk("rst a_res_data",  {16'd0, a_res_data},  32'd0);
    chk("rst b_res_data",  {16'd0, b_res_data},  32'd0);
    qa.delete();
    qb.delete();
    rsp_at = -1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  task automatic run(input int n, input bit rand_traffic);
    for (int i = 0; i < n; i++) begin
      if (rand_traffic) begin
        if (qa.size() < 2 && $urandom_range(99) < 30)
          qa.push_back('{addr: 16'($urandom), data: 16'($urandom), rw: 1'($urandom)});
        if (qb.size() < 2 && $urandom_range(99) < 30)
          qb.push_back('{addr: 16'($urandom), data: 16'($urandom), rw: 1'($urandom)});
      end
      a_req_valid = (qa.size() > 0);
      if (a_req_valid) {a_req_addr, a_req_data, a_req_rw} = qa[0];
      b_req_valid = (qb.size() > 0);
      if (b_req_valid) {b_req_addr, b_req_data, b_req_rw} = qb[0];
      bus_rvalid = (cyc == rsp_at) || ($urandom_range(99) < stray_pct);
      bus_rdata  = (cyc == rsp_at) ? rsp_value : 16'($urandom);
      step();
      if (acc_a) void'(qa.pop_front());
      if (acc_b) void'(qb.pop_front());
      if (bus_valid && !bus_rw && (rsp_rand || rsp_delay > 0)) begin
        rsp_at    = cyc + (rsp_rand ? int'($urandom_range(1, 5)) : rsp_delay);
        rsp_value = rsp_rand ? 16'($urandom) : rsp_value;
      end
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    bus_rvalid  = 1'b0;
  endtask

  initial begin
    a_req_addr = '0; a_req_data = '0; a_req_rw = 1'b0; a_req_valid = 1'b0;
    b_req_addr = '0; b_req_data = '0; b_req_rw = 1'b0; b_req_valid = 1'b0;
    bus_rdata = '0; bus_rvalid = 1'b0;
    rsp_delay = 0; rsp_rand = 1'b0; stray_pct = 0; rsp_value = '0;
    rst = 1'b1;
    #1;
    do_reset();

    // A write, followed by a held A request that must wait two cycles for ready
    qa.push_back('{addr: 16'h1234, data: 16'h5678, rw: 1'b1});
    qa.push_back('{addr: 16'h1111, data: 16'h2222, rw: 1'b1});
    run(8, 1'b0);

    // B read answered three cycles after the bus strobe
    qb.push_back('{addr: 16'hBABE, data: 16'h0000, rw: 1'b0});
    rsp_delay = 3; rsp_value = 16'hBEEF;
    run(10, 1'b0);

    // simultaneous requests after reset: A first, then strict alternation
    do_reset();
    qa.push_back('{addr: 16'hA001, data: 16'h0001, rw: 1'b1});
    qa.push_back('{addr: 16'hA002, data: 16'h0002, rw: 1'b1});
    qb.push_back('{addr: 16'hB001, data: 16'h0011, rw: 1'b1});
    qb.push_back('{addr: 16'hB002, data: 16'h0012, rw: 1'b1});
    run(12, 1'b0);
    for (int i = 0; i < 5; i++) begin
      qa.push_back('{addr: 16'hA100 + 16'(i), data: 16'(i), rw: 1'b1});
      qb.push_back('{addr: 16'hB100 + 16'(i), data: 16'(i), rw: 1'b1});
    end
    run(24, 1'b0);

    // read with no bus response while B keeps requesting
    rsp_delay = 0;
    qa.push_back('{addr: 16'h0D0D, data: 16'h0000, rw: 1'b0});
    qb.push_back('{addr: 16'h0E0E, data: 16'h3333, rw: 1'b1});
    run(200, 1'b0);

    // reset in the middle of an outstanding read, then a normal read
    do_reset();
    qb.push_back('{addr: 16'h0BAD, data: 16'h0000, rw: 1'b0});
    run(6, 1'b0);
    do_reset();
    qa.push_back('{addr: 16'hF00D, data: 16'h0000, rw: 1'b0});
    rsp_delay = 2; rsp_value = 16'hCAFE;
    run(10, 1'b0);

    // stray bus_rvalid in IDLE and ISSUE must be ignored
    stray_pct = 100;
    run(3, 1'b0);
    qa.push_back('{addr: 16'h5555, data: 16'h6666, rw: 1'b1});
    qb.push_back('{addr: 16'h7777, data: 16'h8888, rw: 1'b1});
    run(8, 1'b0);
    stray_pct = 0;

    // random mixed traffic with random response delays and occasional stray strobes
    rsp_rand = 1'b1; stray_pct = 10;
    run(1500, 1'b1);
    rsp_rand = 1'b0; stray_pct = 0;
    qa.delete(); qb.delete();
    run(400, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
